// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and limits for the stopwatch controller
//
// Holds the FSM state encoding, the time-field limits and the display field
// widths used by stopwatch_control and its testbench.

package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // time is zero, not counting
    ST_RUN  = 2'd1,  // counting
    ST_STOP = 2'd2   // time held (non-zero or saturated), not counting
  } sw_state_t;

  localparam int DECS_MAX = 99;
  localparam int SECS_MAX = 59;
  localparam int MINS_MAX = 99;

  localparam int MINS_W = 7;
  localparam int SECS_W = 6;
  localparam int DECS_W = 7;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV enabled cycles
//
// Ports:
//   clock    in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   enable   in  count while high, hold while low
//   restart  in  force the count back to 0 (wins over enable)
//   tick     out one-cycle pulse while enabled and the count equals TICK_DIV-1

module tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A restart in the same cycle discards the terminal count, so a tick can
  // never leak out of a prescaler that is being re-armed.
  assign tick = enable && !restart && (cnt == CNT_LAST);

endmodule

// File: rtl/stopwatch_control.sv
// rtl/stopwatch_control.sv - mm:ss.hh stopwatch with run/stop, clear, lap freeze and overflow
//
// Optional feature: define STOPWATCH_LAP_EN to build the lap register and
// freeze logic; without it the lap input is ignored and lap_active is 0.
//
// Parameters:
//   CLK_FREQ_HZ  input clock frequency in Hz
//   TICK_HZ      count rate (100 = hundredths); CLK_FREQ_HZ/TICK_HZ must be >= 2
//
// Ports:
//   clock                in  system clock, rising edge
//   reset_n              in  asynchronous active-low reset
//   start_stop           in  one-cycle pulse, toggles run/stop
//   clear                in  one-cycle pulse, zeroes time and returns to IDLE
//   lap                  in  one-cycle pulse, toggles the display freeze
//   stopwatch_unit_mins  out displayed minutes 0..99
//   stopwatch_unit_secs  out displayed seconds 0..59
//   stopwatch_unit_decs  out displayed hundredths 0..99
//   running              out high while the time advances
//   lap_active           out high while the display is frozen
//   overflow             out sticky, set when the time saturates at 99:59.99

module stopwatch_control
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TICK_HZ     = 100
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start_stop,
  input  logic              clear,
  input  logic              lap,
  output logic [MINS_W-1:0] stopwatch_unit_mins,
  output logic [SECS_W-1:0] stopwatch_unit_secs,
  output logic [DECS_W-1:0] stopwatch_unit_decs,
  output logic              running,
  output logic              lap_active,
  output logic              overflow
);

  localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;

  sw_state_t state_q, state_n;

  logic tick;
  logic tick_en;
  logic tick_restart;
  logic at_max;

  logic [MINS_W-1:0] t_mins, n_mins;
  logic [SECS_W-1:0] t_secs, n_secs;
  logic [DECS_W-1:0] t_decs, n_decs;

  logic overflow_q;
  logic running_q;
  logic lap_active_q;

  assign at_max = (t_mins == MINS_W'(MINS_MAX)) &&
                  (t_secs == SECS_W'(SECS_MAX)) &&
                  (t_decs == DECS_W'(DECS_MAX));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    if (clear) begin
      state_n = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_stop && !overflow_q) state_n = ST_RUN;
        end
        ST_RUN: begin
          if (start_stop || (tick && at_max)) state_n = ST_STOP;
        end
        ST_STOP: begin
          // A saturated stopwatch stays stopped until cleared.
          if (start_stop && !overflow_q) state_n = ST_RUN;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tick_en      = (state_q == ST_RUN);
    tick_restart = clear || ((state_q != ST_RUN) && (state_n == ST_RUN));
  end

  // running is registered from the next state so it rises on the same edge
  // that enters RUN and carries no decode glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running_q <= 1'b0;
    end else begin
      running_q <= (state_n == ST_RUN);
    end
  end

  // ----------------------------------------------------------- prescaler
  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (tick_en),
    .restart (tick_restart),
    .tick    (tick)
  );

  // -------------------------------------------------------- time counter
  always_comb begin
    n_mins = t_mins;
    n_secs = t_secs;
    n_decs = t_decs;
    if (tick && !at_max) begin
      if (t_decs == DECS_W'(DECS_MAX)) begin
        n_decs = '0;
        if (t_secs == SECS_W'(SECS_MAX)) begin
          n_secs = '0;
          n_mins = t_mins + 1'b1;
        end else begin
          n_secs = t_secs + 1'b1;
        end
      end else begin
        n_decs = t_decs + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t_mins <= '0;
      t_secs <= '0;
      t_decs <= '0;
    end else if (clear) begin
      t_mins <= '0;
      t_secs <= '0;
      t_decs <= '0;
    end else begin
      t_mins <= n_mins;
      t_secs <= n_secs;
      t_decs <= n_decs;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (clear) begin
      overflow_q <= 1'b0;
    end else if (tick && at_max) begin
      overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------- display registers
`ifdef STOPWATCH_LAP_EN
  logic [MINS_W-1:0] lap_mins;
  logic [SECS_W-1:0] lap_secs;
  logic [DECS_W-1:0] lap_decs;

  // Freezing snapshots the current internal time; counting is unaffected.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lap_active_q <= 1'b0;
      lap_mins     <= '0;
      lap_secs     <= '0;
      lap_decs     <= '0;
    end else if (clear) begin
      lap_active_q <= 1'b0;
    end else if (lap) begin
      lap_active_q <= !lap_active_q;
      if (!lap_active_q) begin
        lap_mins <= t_mins;
        lap_secs <= t_secs;
        lap_decs <= t_decs;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stopwatch_unit_mins <= '0;
      stopwatch_unit_secs <= '0;
      stopwatch_unit_decs <= '0;
    end else if (lap_active_q) begin
      stopwatch_unit_mins <= lap_mins;
      stopwatch_unit_secs <= lap_secs;
      stopwatch_unit_decs <= lap_decs;
    end else begin
      stopwatch_unit_mins <= t_mins;
      stopwatch_unit_secs <= t_secs;
      stopwatch_unit_decs <= t_decs;
    end
  end
`else
  logic unused_lap;
  assign unused_lap   = lap;
  assign lap_active_q = 1'b0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stopwatch_unit_mins <= '0;
      stopwatch_unit_secs <= '0;
      stopwatch_unit_decs <= '0;
    end else begin
      stopwatch_unit_mins <= t_mins;
      stopwatch_unit_secs <= t_secs;
      stopwatch_unit_decs <= t_decs;
    end
  end
`endif

  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// tb/tb_stopwatch_control.sv - directed self-checking bench for stopwatch_control (TICK_DIV=10)

module tb_stopwatch_control;
  import stopwatch_pkg::*;

  logic              clock;
  logic              reset_n;
  logic              start_stop;
  logic              clear;
  logic              lap;
  logic [MINS_W-1:0] mins;
  logic [SECS_W-1:0] secs;
  logic [DECS_W-1:0] decs;
  logic              running;
  logic              lap_active;
  logic              overflow;

  int total = 0;
  int bad   = 0;

  stopwatch_control #(
    .CLK_FREQ_HZ (1000),
    .TICK_HZ     (100)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .start_stop          (start_stop),
    .clear               (clear),
    .lap                 (lap),
    .stopwatch_unit_mins (mins),
    .stopwatch_unit_secs (secs),
    .stopwatch_unit_decs (decs),
    .running             (running),
    .lap_active          (lap_active),
    .overflow            (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Display packed as mmssdd for compact expectations.
  function automatic int disp();
    return int'(mins) * 10000 + int'(secs) * 100 + int'(decs);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // All pulse tasks start and end on a falling edge; the pulse is sampled
  // at the rising edge in between.
  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clock);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    @(negedge clock);
    lap = 1'b0;
  endtask

  task automatic preload(input int m, input int s, input int d);
    force dut.t_mins = MINS_W'(m);
    force dut.t_secs = SECS_W'(s);
    force dut.t_decs = DECS_W'(d);
    @(negedge clock);
    release dut.t_mins;
    release dut.t_secs;
    release dut.t_decs;
    @(negedge clock);
  endtask

  initial begin
    reset_n    = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    wait_cyc(3);

    // Reset state
    check("rst_disp", disp(), 0);
    check("rst_running", running, 0);
    check("rst_lap", lap_active, 0);
    check("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    wait_cyc(2);

    // Start, first-tick latency, one second of counting
    pulse_ss();
    check("start_running", running, 1);
    check("start_disp0", disp(), 0);
    wait_cyc(10);
    check("pre_tick_disp", disp(), 0);
    wait_cyc(1);
    check("first_tick_disp", disp(), 1);
    wait_cyc(990);
    check("one_sec_disp", disp(), 100);

    // Stop holds time
    pulse_ss();
    check("stop_running", running, 0);
    wait_cyc(50);
    check("stop_hold_disp", disp(), 100);

    // Resume restarts the prescaler
    pulse_ss();
    check("resume_running", running, 1);
    wait_cyc(10);
    check("resume_pre_tick", disp(), 100);
    wait_cyc(1);
    check("resume_tick", disp(), 101);

    // Clear and start_stop together while running
    clear      = 1'b1;
    start_stop = 1'b1;
    @(negedge clock);
    clear      = 1'b0;
    start_stop = 1'b0;
    check("clr_ss_running", running, 0);
    wait_cyc(1);
    check("clr_ss_disp", disp(), 0);
    wait_cyc(30);
    check("clr_ss_idle_hold", disp(), 0);

    // Seconds-to-minutes carry, no illegal intermediate values
    preload(0, 59, 99);
    check("carry_preload", disp(), 5999);
    pulse_ss();
    for (int i = 1; i <= 11; i++) begin
      @(negedge clock);
      check("carry_legal", (secs <= 6'd59 && decs <= 7'd99) ? 1 : 0, 1);
      if (i == 10) check("carry_before", disp(), 5999);
      if (i == 11) check("carry_after", disp(), 10000);
    end
    pulse_clear();

    // Saturation at 99:59.99
    preload(99, 59, 98);
    pulse_ss();
    wait_cyc(11);
    check("sat_last_disp", disp(), 995999);
    check("sat_no_ovf_yet", overflow, 0);
    wait_cyc(10);
    check("sat_disp", disp(), 995999);
    check("sat_ovf", overflow, 1);
    check("sat_running", running, 0);
    pulse_ss();
    check("sat_ss_ignored", running, 0);
    wait_cyc(30);
    check("sat_hold_disp", disp(), 995999);
    check("sat_hold_ovf", overflow, 1);
    pulse_clear();
    check("sat_clr_ovf", overflow, 0);
    wait_cyc(1);
    check("sat_clr_disp", disp(), 0);

`ifdef STOPWATCH_LAP_EN
    // Lap freeze and release
    pulse_ss();
    wait_cyc(501);
    check("lap_pre_disp", disp(), 50);
    pulse_lap();
    check("lap_active_set", lap_active, 1);
    check("lap_frozen_0", disp(), 50);
    for (int k = 1; k <= 3; k++) begin
      wait_cyc(k == 3 ? 99 : 100);
      check("lap_frozen", disp(), 50);
    end
    check("lap_still_running", running, 1);
    pulse_lap();
    check("lap_active_clr", lap_active, 0);
    wait_cyc(1);
    check("lap_release_disp", disp(), 80);
    pulse_lap();
    pulse_clear();
    check("lap_clr_active", lap_active, 0);
`else
    // Lap input has no effect
    pulse_ss();
    wait_cyc(101);
    pulse_lap();
    check("nolap_active", lap_active, 0);
    wait_cyc(100);
    check("nolap_disp", disp(), 20);
    pulse_clear();
`endif

    // Asynchronous reset mid-run
    wait_cyc(2);
    pulse_ss();
    wait_cyc(12341);
    check("pre_rst_disp", disp(), 1234);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_disp", disp(), 0);
    check("async_rst_running", running, 0);
    check("async_rst_ovf", overflow, 0);
    check("async_rst_lap", lap_active, 0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_cyc(20);
    check("post_rst_running", running, 0);
    check("post_rst_disp", disp(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_control.md
STOPWATCH_CONTROL -- requirements
Module: stopwatch_control

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 50000000, giving the input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 100, giving the count rate in hundredths of a second; TICK_DIV = CLK_FREQ_HZ/TICK_HZ, which SHALL be at least 2.
REQ-003 The block SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start_stop, input, 1 bit: one-cycle pulse, already debounced and synchronised, that toggles between run and stop.
REQ-006 The block SHALL have port clear, input, 1 bit: one-cycle pulse that zeroes the time.
REQ-007 The block SHALL have port lap, input, 1 bit: one-cycle pulse that toggles the lap freeze.
REQ-008 The block SHALL have port stopwatch_unit_mins, output, 7 bits: displayed minutes, 0..99.
REQ-009 The block SHALL have port stopwatch_unit_secs, output, 6 bits: displayed seconds, 0..59.
REQ-010 The block SHALL have port stopwatch_unit_decs, output, 7 bits: displayed hundredths, 0..99.
REQ-011 The block SHALL have port running, output, 1 bit: high while the counters advance.
REQ-012 The block SHALL have port lap_active, output, 1 bit: high while the display is frozen.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag, set when the time saturates.

Function
REQ-014 The FSM SHALL have states IDLE (zero, stopped), RUN and STOP (non-zero, stopped).
REQ-015 start_stop SHALL take IDLE->RUN, RUN->STOP and STOP->RUN; running SHALL be high in the cycle after the pulse that enters RUN.
REQ-016 The prescaler SHALL restart at 0 on every entry to RUN and SHALL issue a one-cycle tick when the count equals TICK_DIV-1, so the first increment lands exactly TICK_DIV cycles after running rises.
REQ-017 Each tick in RUN SHALL increment the internal time: hundredths wrap 99->0 and carry into seconds; seconds wrap 59->0 and carry into minutes.
REQ-018 At 99:59.99 the next tick SHALL hold the time at 99:59.99, set overflow, and move the FSM to STOP.
REQ-019 In STOP the prescaler SHALL hold and the time SHALL be held.
REQ-020 clear SHALL zero the time, the prescaler, overflow and lap_active, and SHALL move the FSM to IDLE from any state, taking effect on the next edge.
REQ-021 clear SHALL have priority over start_stop and lap in the same cycle.
REQ-022 start_stop and lap asserted together SHALL both be honoured.
REQ-023 The outputs SHALL be registered and SHALL show the internal time when lap_active is 0, or the latched lap value when lap_active is 1; output latency is one cycle from the internal update.
REQ-024 start_stop while at overflow SHALL be ignored until clear.

Reset
REQ-025 While reset_n is low, the FSM SHALL be IDLE, the prescaler 0 and the time 0, and all outputs SHALL be 0: mins, secs, decs, running, lap_active and overflow.
REQ-026 Deassertion of reset_n mid-run SHALL resume in IDLE; no pulse captured before reset SHALL take effect.

Configuration
REQ-027 With macro STOPWATCH_LAP_EN defined, a lap pulse with lap_active=0 SHALL copy the internal time into the lap register and set lap_active; a lap pulse with lap_active=1 SHALL clear it. Counting SHALL continue in either case.
REQ-028 With STOPWATCH_LAP_EN undefined, the lap input SHALL be ignored, lap_active SHALL be tied to 0, and no lap register SHALL be synthesised.

Structure
REQ-029 Package stopwatch_pkg SHALL hold the FSM state enum (IDLE/RUN/STOP), the limit constants DECS_MAX=99, SECS_MAX=59 and MINS_MAX=99, and the output widths 7/6/7.
REQ-030 The prescaler SHALL be sub-module tick_gen, with parameter TICK_DIV and ports clock, reset_n, enable, restart and tick.
REQ-031 The outputs SHALL connect directly to the existing seven-segment encoder's stopwatch_unit_* inputs.

Verification (CLK_FREQ_HZ=1000, TICK_HZ=100, TICK_DIV=10)
REQ-032 Scenario: reset, then start_stop at cycle 0 -> running=1 at cycle 1 and decs=1 at cycle 11 (±1 output register); after 1000 cycles running, time reads 00:01.00.
REQ-033 Scenario: run to 00:59.99 and tick once -> output reads 01:00.00 with no intermediate illegal value.
REQ-034 Scenario: preload 99:59.98 through a bench hierarchy force and tick twice -> output reads 99:59.99, overflow=1, running=0; a later start_stop is ignored.
REQ-035 Scenario: clear and start_stop in the same cycle while in RUN -> IDLE, all zero, running=0.
REQ-036 Scenario (STOPWATCH_LAP_EN): lap at 00:00.50 -> display frozen at 00:00.50 for 300 cycles; a second lap -> display shows 00:00.80.
REQ-037 Scenario: reset_n asserted mid-run at 00:12.34 -> all outputs 0 immediately, without waiting for a clock edge.
